// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and small helpers for the
// pixel-write / scan-out path.
package vga_timing_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;

  localparam int H_VIS    = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS    = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int ADDR_W   = 17;
  localparam int COLOUR_W = 6;
  localparam int CNT_W    = 10;

  // Per-pixel sync/blank bundle, carried alongside the RAM read latency.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

  // y*320 + x built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] x,
                                                   input logic [8:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 8) + (yy << 6) + ADDR_W'(x);
  endfunction

  // Two-bit DAC code replicated across the eight output bits.
  function automatic logic [7:0] expand_channel(input logic [1:0] c);
    return {4{c}};
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// read-before-write on address collision.
module frame_buffer_ram #(
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 6
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register; a reset would prevent
  // block-RAM inference and the contents are defined only by writes.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_frame_scanner.sv
// Stores datapath pixel writes in a 320x240x6 buffer and scans it out as
// 640x480@60 VGA with every stored pixel doubled 2x2.
module vga_frame_scanner
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VIS,
  parameter int H_FRONT    = H_FP,
  parameter int H_SYNC_LEN = H_SYNC,
  parameter int H_BACK     = H_BP,
  parameter int V_VISIBLE  = V_VIS,
  parameter int V_FRONT    = V_FP,
  parameter int V_SYNC_LEN = V_SYNC,
  parameter int V_BACK     = V_BP
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [8:0]          x_position,
  input  logic [7:0]          y_position,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                VGA_enable,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic                VGA_CLK,
  output logic                frame_start
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC_LEN + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC_LEN + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC_LEN - 1);
  localparam logic [8:0]       FB_W_X     = 9'(FB_W);
  localparam logic [7:0]       FB_H_Y     = 8'(FB_H);

  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick        <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      tick        <= ~tick;
      frame_start <= 1'b0;
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
          if (v_cnt == V_VIS_LAST) frame_start <= 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  logic visible;
  sync_t sync_now;

  assign visible          = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign sync_now.hs_n    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign sync_now.vs_n    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  assign sync_now.blank_n = visible;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOUR_W-1:0] rd_data;

  // Out-of-range writes are dropped; there is no backpressure.
  assign wr_en   = VGA_enable && (x_position < FB_W_X) && (y_position < FB_H_Y);
  assign wr_addr = pixel_addr(x_position, {1'b0, y_position});
  assign rd_addr = visible ? pixel_addr(h_cnt[CNT_W-1:1], v_cnt[CNT_W-1:1]) : '0;

  frame_buffer_ram #(
    .DEPTH  (FB_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOUR_W)
  ) u_frame_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (colour),
    .rd_en   (visible),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage 1 lines sync/blank up with the RAM read; stage 2 drives the pins,
  // so every output trails its counter value by exactly two clocks.
  sync_t sync_d1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_d1     <= SYNC_IDLE;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      sync_d1     <= sync_now;
      VGA_HS      <= sync_d1.hs_n;
      VGA_VS      <= sync_d1.vs_n;
      VGA_BLANK_N <= sync_d1.blank_n;
      VGA_R       <= sync_d1.blank_n ? expand_channel(rd_data[5:4]) : 8'h00;
      VGA_G       <= sync_d1.blank_n ? expand_channel(rd_data[3:2]) : 8'h00;
      VGA_B       <= sync_d1.blank_n ? expand_channel(rd_data[1:0]) : 8'h00;
    end
  end

  assign VGA_SYNC_N = 1'b0;
  assign VGA_CLK    = tick;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner: full horizontal timing, a short
// 17-line frame so frame-level behaviour fits in a compact run.
module tb_vga_frame_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] x_position;
  logic [7:0] y_position;
  logic [5:0] colour;
  logic       VGA_enable;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start;

  int unsigned edge_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  vga_frame_scanner #(
    .V_VISIBLE  (12),
    .V_FRONT    (1),
    .V_SYNC_LEN (2),
    .V_BACK     (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .x_position  (x_position),
    .y_position  (y_position),
    .colour      (colour),
    .VGA_enable  (VGA_enable),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK),
    .frame_start (frame_start)
  );

  always #10 clock = ~clock;

  // Clock edges since the last reset release; edge k holds counter index k>>1.
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_edge(input int unsigned n);
    while (edge_cnt < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Output for screen pixel (h,v) appears two clocks after the counters reach it.
  function automatic int unsigned pix_edge(input int h, input int v);
    return 2 * (v * 800 + h) + 2;
  endfunction

  task automatic check_pixel(input string tag, input int h, input int v,
                             input int r, input int g, input int b);
    wait_edge(pix_edge(h, v));
    check({tag, ".blank_n"}, 32'(VGA_BLANK_N), 1);
    check({tag, ".r"}, 32'(VGA_R), r);
    check({tag, ".g"}, 32'(VGA_G), g);
    check({tag, ".b"}, 32'(VGA_B), b);
  endtask

  task automatic write_pixel(input int x, input int y, input logic [5:0] c);
    x_position = 9'(x);
    y_position = 8'(y);
    colour     = c;
    VGA_enable = 1'b1;
    wait_edge(edge_cnt + 1);
    VGA_enable = 1'b0;
  endtask

  initial begin
    int hs_fall, hs_low, blank_hi, vs_low, fs_edge, fs_count;

    reset      = 1'b0;
    x_position = '0;
    y_position = '0;
    colour     = '0;
    VGA_enable = 1'b0;

    // Reset held for 10 clocks.
    repeat (10) @(posedge clock);
    #1;
    check("rst.hs", 32'(VGA_HS), 1);
    check("rst.vs", 32'(VGA_VS), 1);
    check("rst.blank_n", 32'(VGA_BLANK_N), 0);
    check("rst.rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
    check("rst.frame_start", 32'(frame_start), 0);
    check("rst.sync_n", 32'(VGA_SYNC_N), 0);
    check("rst.vga_clk", 32'(VGA_CLK), 0);
    @(negedge clock) reset = 1'b1;

    wait_edge(1);
    check("rel.blank_n_e1", 32'(VGA_BLANK_N), 0);
    check("rel.rgb_e1", 32'({VGA_R, VGA_G, VGA_B}), 0);
    check("rel.vga_clk_e1", 32'(VGA_CLK), 1);

    // Line 0: HS fall position, HS width, visible width.
    hs_fall = 0; hs_low = 0; blank_hi = 0; vs_low = 0;
    for (int e = 2; e <= 1601; e++) begin
      wait_edge(e);
      if (!VGA_HS) begin
        hs_low++;
        if (hs_fall == 0) hs_fall = e;
      end
      if (VGA_BLANK_N) blank_hi++;
      if (!VGA_VS) vs_low++;
    end
    check("line0.first_hs_fall", hs_fall, 1314);
    check("line0.hs_low_clocks", hs_low, 192);
    check("line0.blank_hi_clocks", blank_hi, 1280);
    check("line0.vs_low_clocks", vs_low, 0);

    hs_fall = 0;
    for (int e = 1602; e <= 3200; e++) begin
      wait_edge(e);
      if (!VGA_HS && hs_fall == 0) hs_fall = e;
    end
    check("line1.hs_fall_period", hs_fall - 1314, 1600);

    // Backgrounds, the target pixel, then two out-of-range writes.
    write_pixel(0, 1, 6'b000001);
    write_pixel(4, 3, 6'b001100);
    write_pixel(6, 3, 6'b000011);
    write_pixel(5, 2, 6'b101010);
    write_pixel(5, 3, 6'b110000);
    write_pixel(320, 0, 6'b111111);
    write_pixel(0, 240, 6'b111111);

    check_pixel("oor.v3h0", 0, 3, 'h00, 'h00, 'h55);
    check_pixel("oor.v3h1", 1, 3, 'h00, 'h00, 'h55);
    check_pixel("above.v4h10", 10, 4, 'hAA, 'hAA, 'hAA);
    check_pixel("left.v6h8", 8, 6, 'h00, 'hFF, 'h00);
    check_pixel("tgt.v6h10", 10, 6, 'hFF, 'h00, 'h00);
    check_pixel("tgt.v6h11", 11, 6, 'hFF, 'h00, 'h00);
    check_pixel("right.v6h12", 12, 6, 'h00, 'h00, 'hFF);
    check_pixel("right.v6h13", 13, 6, 'h00, 'h00, 'hFF);
    check_pixel("tgt.v7h10", 10, 7, 'hFF, 'h00, 'h00);
    check_pixel("tgt.v7h11", 11, 7, 'hFF, 'h00, 'h00);

    wait_edge(pix_edge(700, 7));
    check("blank.v7h700.blank_n", 32'(VGA_BLANK_N), 0);
    check("blank.v7h700.rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);

    // Mid-frame reset with counters at (300,8).
    wait_edge(pix_edge(300, 8) - 2);
    check("midrst.pre_blank_n", 32'(VGA_BLANK_N), 1);
    reset = 1'b0;
    #1;
    check("midrst.hs", 32'(VGA_HS), 1);
    check("midrst.vs", 32'(VGA_VS), 1);
    check("midrst.blank_n", 32'(VGA_BLANK_N), 0);
    check("midrst.rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
    check("midrst.vga_clk", 32'(VGA_CLK), 0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    wait_edge(1);
    check("restart.blank_n_e1", 32'(VGA_BLANK_N), 0);
    wait_edge(2);
    check("restart.blank_n_e2", 32'(VGA_BLANK_N), 1);
    check_pixel("kept.v3h0", 0, 3, 'h00, 'h00, 'h55);
    check_pixel("kept.v6h10", 10, 6, 'hFF, 'h00, 'h00);

    // frame_start timing and VS width over one 17-line frame.
    wait_edge(19199);
    check("fs.before", 32'(frame_start), 0);
    wait_edge(19200);
    check("fs.first_pulse", 32'(frame_start), 1);
    wait_edge(19201);
    check("fs.one_clock", 32'(frame_start), 0);

    fs_edge = 0; fs_count = 0; vs_low = 0;
    for (int e = 19202; e <= 46500; e++) begin
      wait_edge(e);
      if (!VGA_VS) vs_low++;
      if (frame_start) begin
        fs_count++;
        if (fs_edge == 0) fs_edge = e;
      end
    end
    check("fs.period", fs_edge - 19200, 27200);
    check("fs.pulses_per_frame", fs_count, 1);
    check("vs.low_clocks", vs_low, 3200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
